load_requester: RTL and testbench

- Initiator side of the memory load port.
- Accepts CPU load requests (16-bit word address plus tag) over a valid/ready handshake and drives loadEnable/loadAddr toward memory.
- Tracks in-flight requests in issue order. The memory returns responses in order, at fixed latency, with no backpressure.
- For each response, extracts the addressed 16-bit word from the 64-bit block and delivers it with its tag through a buffered valid/ready result port.
- A credit counter bounds in-flight plus buffered results, so results are never dropped.

---
 rtl/load_requester.sv | 171 +++++++++++++++++
 tb/tb_load_requester.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_requester.sv
// Memory load initiator: issues CPU loads, matches in-order responses, returns selected word + tag. Optional watchdog: LOAD_WATCHDOG_EN.
// Latency: load issue 1 cycle after accept; result visible 1 + memory latency after accept.
// Backpressure: credit counter bounds in-flight + buffered results; reqReady drops at zero credits.

// Generic synchronous FIFO with first-word fall-through head and occupancy count.
// Latency: pushed data visible at head the cycle after push.
// Backpressure: none internally; callers guarantee no push when full and no pop when empty.
module syncFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= pushData;
    end

    // Extra pointer bit separates full (count == DEPTH) from empty.
    assign headData = mem[rdPtr[AW-1:0]];
    assign count    = wrPtr - rdPtr;
endmodule

module load_requester #(
    parameter int DEPTH   = 8,
    parameter int TAGW    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic [15:0]              reqAddr,
    input  logic [TAGW-1:0]          reqTag,
    output logic                     loadEnable,
    output logic [15:0]              loadAddr,
    input  logic                     loadReady,
    input  logic [63:0]              loadData,
    output logic                     resValid,
    input  logic                     resReady,
    output logic [15:0]              resData,
    output logic [TAGW-1:0]          resTag,
    output logic [$clog2(DEPTH):0]   inFlight,
    output logic                     protoErr,
    output logic                     timeoutErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CRED_ONE = {{AW{1'b0}}, 1'b1};

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : gBadParam
            $error("load_requester: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    logic [CW-1:0]     credits;
    logic [CW-1:0]     metaCount;
    logic [CW-1:0]     resCount;
    logic [TAGW+1:0]   metaHead;
    logic [TAGW+15:0]  resHead;
    logic [15:0]       selWord;
    logic              accept;
    logic              metaEmpty;
    logic              respond;
    logic              resPop;

    assign reqReady  = (credits != '0);
    assign accept    = reqValid && reqReady;
    assign metaEmpty = (metaCount == '0);
    assign respond   = loadReady && !metaEmpty;
    assign resValid  = (resCount != '0);
    assign resPop    = resValid && resReady;
    assign inFlight  = metaCount;

    syncFifo #(.WIDTH(TAGW + 2), .DEPTH(DEPTH)) uMetaFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .pushData ({reqTag, reqAddr[1:0]}),
        .pop      (respond),
        .headData (metaHead),
        .count    (metaCount)
    );

    // Word 0 sits in the most significant lane of the block.
    always_comb begin
        selWord = loadData[15:0];
        case (metaHead[1:0])
            2'd0:    selWord = loadData[63:48];
            2'd1:    selWord = loadData[47:32];
            2'd2:    selWord = loadData[31:16];
            default: selWord = loadData[15:0];
        endcase
    end

    syncFifo #(.WIDTH(TAGW + 16), .DEPTH(DEPTH)) uResFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (respond),
        .pushData ({metaHead[TAGW+1:2], selWord}),
        .pop      (resPop),
        .headData (resHead),
        .count    (resCount)
    );

    // Masked so the result port reads zero while empty (storage is not reset).
    assign resData = resValid ? resHead[15:0]       : 16'h0000;
    assign resTag  = resValid ? resHead[TAGW+15:16] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits    <= CW'(DEPTH);
            loadEnable <= 1'b0;
            loadAddr   <= 16'h0000;
            protoErr   <= 1'b0;
        end else begin
            case ({accept, resPop})
                2'b10:   credits <= credits - CRED_ONE;
                2'b01:   credits <= credits + CRED_ONE;
                default: credits <= credits;
            endcase
            loadEnable <= accept;
            if (accept) loadAddr <= reqAddr;
            if (loadReady && metaEmpty) protoErr <= 1'b1;
        end
    end

`ifdef LOAD_WATCHDOG_EN
    localparam int AGEW = $clog2(TIMEOUT + 2);

    logic [AGEW-1:0] age;

    // Flag on the cycle the age would step past TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age        <= '0;
            timeoutErr <= 1'b0;
        end else if (metaEmpty || respond) begin
            age <= '0;
        end else begin
            if (age != '1) age <= age + {{(AGEW-1){1'b0}}, 1'b1};
            if (age >= AGEW'(TIMEOUT)) timeoutErr <= 1'b1;
        end
    end
`else
    assign timeoutErr = 1'b0;
`endif
endmodule

// File: tb/tb_load_requester.sv
// Randomized scoreboard bench for load_requester with an in-order fixed-latency memory model.
module tb_load_requester;
    localparam int DEPTH   = 8;
    localparam int TAGW    = 4;
    localparam int TIMEOUT = 20;

    logic             clk;
    logic             rst_n;
    logic             reqValid;
    logic             reqReady;
    logic [15:0]      reqAddr;
    logic [TAGW-1:0]  reqTag;
    logic             loadEnable;
    logic [15:0]      loadAddr;
    logic             loadReady;
    logic [63:0]      loadData;
    logic             resValid;
    logic             resReady;
    logic [15:0]      resData;
    logic [TAGW-1:0]  resTag;
    logic [3:0]       inFlight;
    logic             protoErr;
    logic             timeoutErr;

    load_requester #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqTag(reqTag),
        .loadEnable(loadEnable), .loadAddr(loadAddr), .loadReady(loadReady), .loadData(loadData),
        .resValid(resValid), .resReady(resReady), .resData(resData), .resTag(resTag),
        .inFlight(inFlight), .protoErr(protoErr), .timeoutErr(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] addr; } memEnt_t;

    int checks = 0;
    int errors = 0;
    int nCyc = 0;
    int memLat = 4;
    int peak = 0;
    bit useFixed = 0;
    bit memOff = 0;
    bit spurious = 0;
    logic [TAGW+15:0] sbQ[$];
    logic [15:0]      issueQ[$];
    memEnt_t          memQ[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] memBlock(input logic [15:0] a);
        if (useFixed) return 64'h1111_2222_3333_4444;
        return {a ^ 16'h5A5A, a + 16'h0101, ~a, {a[7:0], a[15:8]}};
    endfunction

    // Word n of the block counts down from the top lane.
    function automatic logic [15:0] expWord(input logic [15:0] a);
        logic [63:0] blk;
        blk = memBlock(a);
        return 16'(blk >> (16 * (3 - int'(a[1:0]))));
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [TAGW-1:0] t, output bit acc);
        reqValid = 1'b1;
        reqAddr  = a;
        reqTag   = t;
        acc      = reqReady;
        if (acc) begin
            sbQ.push_back({t, expWord(a)});
            issueQ.push_back(a);
        end
    endtask

    task automatic drain();
        reqValid = 1'b0;
        resReady = 1'b1;
        for (int i = 0; i < 2000 && (sbQ.size() != 0 || inFlight != 0); i++) step();
        chk("drain_empty", {63'd0, sbQ.size() == 0}, 64'd1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        reqValid = 1'b0;
        resReady = 1'b0;
        sbQ.delete();
        issueQ.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Memory: sees the strobe, answers memLat cycles later, in order.
    initial begin
        memEnt_t e;
        loadReady = 1'b0;
        loadData  = '0;
        forever begin
            @(negedge clk);
            nCyc++;
            if (!rst_n) begin
                memQ.delete();
                loadReady = 1'b0;
                continue;
            end
            if (loadEnable) begin
                if (issueQ.size() == 0) chk("load_unexpected", {48'd0, loadAddr}, 64'hFFFF_FFFF);
                else chk("load_addr", {48'd0, loadAddr}, {48'd0, issueQ.pop_front()});
                if (!memOff) memQ.push_back('{nCyc + memLat, loadAddr});
            end
            loadReady = spurious;
            loadData  = '0;
            if (memQ.size() > 0 && memQ[0].due == nCyc) begin
                e = memQ.pop_front();
                loadReady = 1'b1;
                loadData  = memBlock(e.addr);
            end
        end
    end

    // Result monitor: head must match the oldest outstanding expectation every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) continue;
            if (int'(inFlight) > peak) peak = int'(inFlight);
            if (resValid) begin
                if (sbQ.size() == 0) chk("result_unexpected", {44'd0, resTag, resData}, 64'hFFFF_FFFF);
                else chk("result", {44'd0, resTag, resData}, {44'd0, sbQ[0]});
                if (resReady && sbQ.size() != 0) void'(sbQ.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=<50000 cycles", nCyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit acc;
        int steps;
        int nAcc;
        int simul;
        rst_n = 1'b1;
        reqValid = 1'b0; reqAddr = '0; reqTag = '0; resReady = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        chk("rst_reqReady", {63'd0, reqReady}, 64'd1);
        chk("rst_loadEnable", {63'd0, loadEnable}, 64'd0);
        chk("rst_loadAddr", {48'd0, loadAddr}, 64'd0);
        chk("rst_resValid", {63'd0, resValid}, 64'd0);
        chk("rst_resData", {48'd0, resData}, 64'd0);
        chk("rst_resTag", {60'd0, resTag}, 64'd0);
        chk("rst_inFlight", {60'd0, inFlight}, 64'd0);
        chk("rst_protoErr", {63'd0, protoErr}, 64'd0);
        chk("rst_timeoutErr", {63'd0, timeoutErr}, 64'd0);

        // Single load, 100-cycle memory.
        useFixed = 1; memLat = 100; resReady = 1'b1;
        issue(16'h0006, 4'd5, acc);
        chk("single_accept", {63'd0, acc}, 64'd1);
        step(); reqValid = 1'b0; steps = 1;
        chk("single_loadEnable", {63'd0, loadEnable}, 64'd1);
        chk("single_loadAddr", {48'd0, loadAddr}, 64'h6);
        step(); steps++;
        chk("single_loadEnable_pulse", {63'd0, loadEnable}, 64'd0);
        while (!resValid && steps < 300) begin step(); steps++; end
        chk("single_latency", 64'(steps - 1), 64'd101);
        chk("single_resData", {48'd0, resData}, 64'h3333);
        chk("single_resTag", {60'd0, resTag}, 64'd5);
        drain();
        useFixed = 0;

        // Credit exhaustion with the result port stalled.
        memLat = 20; resReady = 1'b0; peak = 0; nAcc = 0;
        for (int i = 0; i < 10; i++) begin
            issue(16'($urandom), 4'(i), acc);
            if (acc) nAcc++;
            step();
        end
        reqValid = 1'b0;
        chk("credit_accepts", 64'(nAcc), 64'd8);
        chk("credit_reqReady_low", {63'd0, reqReady}, 64'd0);
        for (int i = 0; i < 200 && inFlight != 0; i++) step();
        chk("credit_peak", 64'(peak), 64'd8);
        chk("credit_buffered", {63'd0, resValid}, 64'd1);
        chk("credit_still_blocked", {63'd0, reqReady}, 64'd0);
        resReady = 1'b1; step(); resReady = 1'b0;
        chk("credit_reqReady_back", {63'd0, reqReady}, 64'd1);
        issue(16'($urandom), 4'd8, acc);
        chk("credit_req8_accept", {63'd0, acc}, 64'd1);
        step();
        drain();

        // Steady stream: accept, response and pop in one cycle.
        memLat = 4; resReady = 1'b1; simul = 0;
        for (int i = 0; i < 16; i++) begin
            issue(16'($urandom), 4'(i), acc);
            chk("stream_accept", {63'd0, acc}, 64'd1);
            if (i >= 8) chk("stream_inFlight", {60'd0, inFlight}, 64'(memLat + 1));
            if (loadReady && loadEnable && resValid && resReady && reqReady) simul++;
            step();
        end
        chk("stream_simultaneous", {63'd0, simul > 0}, 64'd1);
        drain();

        // Random traffic with varying latency.
        for (int ph = 0; ph < 4; ph++) begin
            memLat = $urandom_range(1, 6);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 9) < 7) issue(16'($urandom), 4'($urandom), acc);
                else reqValid = 1'b0;
                resReady = ($urandom_range(0, 9) < 6);
                step();
            end
            drain();
        end

        // Spurious response after reset.
        doReset();
        spurious = 1; step(); spurious = 0; step();
        chk("spurious_protoErr", {63'd0, protoErr}, 64'd1);
        chk("spurious_resValid", {63'd0, resValid}, 64'd0);
        repeat (5) step();
        chk("spurious_sticky", {63'd0, protoErr}, 64'd1);
        chk("spurious_inFlight", {60'd0, inFlight}, 64'd0);

        // Reset mid-operation.
        memLat = 50; resReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(16'h0100 + 16'(i), 4'(i), acc);
            step();
        end
        reqValid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_loadEnable", {63'd0, loadEnable}, 64'd0);
        chk("midrst_loadAddr", {48'd0, loadAddr}, 64'd0);
        chk("midrst_resValid", {63'd0, resValid}, 64'd0);
        chk("midrst_inFlight", {60'd0, inFlight}, 64'd0);
        chk("midrst_protoErr", {63'd0, protoErr}, 64'd0);
        chk("midrst_reqReady", {63'd0, reqReady}, 64'd1);
        sbQ.delete(); issueQ.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        memLat = 5; nAcc = 0;
        for (int i = 0; i < 9; i++) begin
            issue(16'($urandom), 4'(i), acc);
            if (acc) nAcc++;
            step();
        end
        chk("midrst_credits", 64'(nAcc), 64'd8);
        drain();
        chk("midrst_no_proto", {63'd0, protoErr}, 64'd0);

        // Watchdog: memory never answers.
        memOff = 1;
        doReset();
        issue(16'h0042, 4'd3, acc);
        step(); reqValid = 1'b0; steps = 1;
`ifdef LOAD_WATCHDOG_EN
        while (!timeoutErr && steps < 100) begin step(); steps++; end
        chk("watchdog_latency", 64'(steps - 1), 64'd21);
        repeat (3) step();
        chk("watchdog_sticky", {63'd0, timeoutErr}, 64'd1);
`else
        repeat (40) step();
        chk("watchdog_off", {63'd0, timeoutErr}, 64'd0);
`endif
        memOff = 0;
        doReset();
        chk("final_timeoutErr", {63'd0, timeoutErr}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
